// File: rtl/pc_sequencer_if.sv
// Fetch/redirect/instruction bus between the PC sequencer and its surroundings.
// The master side is the sequencer; the slave side is memory plus pipeline.
interface pc_sequencer_if #(
  parameter int BITSIZE = 32
);
  logic               Stall;
  logic               BranchTaken;
  logic [BITSIZE-1:0] BranchPC;
  logic [BITSIZE-1:0] Immediate;
  logic               JumpEn;
  logic [BITSIZE-1:0] JumpTarget;
  logic               IMemReq;
  logic [BITSIZE-1:0] IMemAddr;
  logic               IMemAck;
  logic [BITSIZE-1:0] IMemData;
  logic               InstrValid;
  logic [BITSIZE-1:0] Instr;
  logic [BITSIZE-1:0] InstrPC;
  logic               Flush;

  modport master (
    input  Stall, BranchTaken, BranchPC, Immediate, JumpEn, JumpTarget,
    input  IMemAck, IMemData,
    output IMemReq, IMemAddr, InstrValid, Instr, InstrPC, Flush
  );

  modport slave (
    output Stall, BranchTaken, BranchPC, Immediate, JumpEn, JumpTarget,
    output IMemAck, IMemData,
    input  IMemReq, IMemAddr, InstrValid, Instr, InstrPC, Flush
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: fetches sequential words, holds one instruction for the
// pipeline, honours stalls and redirects (jump over branch), pulses Flush.
module pc_sequencer #(
  parameter int                 BITSIZE      = 32,
  parameter logic [BITSIZE-1:0] RESET_VECTOR = {BITSIZE{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  pc_sequencer_if.master         bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BITSIZE-1:0] r_pc;
  logic [BITSIZE-1:0] w_pc_nxt;
  logic [BITSIZE-1:0] r_instr;
  logic [BITSIZE-1:0] w_instr_nxt;
  logic [BITSIZE-1:0] r_instr_pc;
  logic [BITSIZE-1:0] w_instr_pc_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_flush;
  logic               w_flush_nxt;

  logic               w_redirect;
  logic [BITSIZE-1:0] w_jump_target;
  logic [BITSIZE-1:0] w_branch_target;
  logic [BITSIZE-1:0] w_target;

  // Redirects are only honoured once the sequencer has left IDLE.
  assign w_redirect      = (r_state != S_IDLE) && (bus.JumpEn || bus.BranchTaken);
  assign w_jump_target   = {bus.JumpTarget[BITSIZE-1:2], 2'b00};
  // Immediate counts words; the shift and add wrap modulo 2^BITSIZE.
  assign w_branch_target = bus.BranchPC + (bus.Immediate << 2);
  assign w_target        = bus.JumpEn ? w_jump_target : w_branch_target;

  // Next-state and datapath update; every field defaults to holding.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_flush_nxt    = 1'b0;
    if (w_redirect) begin
      // Ack and Stall in this cycle are both discarded.
      w_state_nxt = S_FETCH;
      w_pc_nxt    = w_target;
      w_valid_nxt = 1'b0;
      w_flush_nxt = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_FETCH;
        end
        S_FETCH: begin
          if (r_valid && bus.Stall) begin
            // Held instruction not consumed: park, refuse this ack.
            w_state_nxt = S_STALL;
          end else if (bus.IMemAck) begin
            w_instr_nxt    = bus.IMemData;
            w_instr_pc_nxt = r_pc;
            w_valid_nxt    = 1'b1;
            w_pc_nxt       = r_pc + 32'd4;
          end else begin
            // Held instruction consumed and nothing new arrived.
            w_valid_nxt = 1'b0;
          end
        end
        S_STALL: begin
          if (!bus.Stall) begin
            // Instruction consumed this cycle; do not present it again.
            w_state_nxt = S_FETCH;
            w_valid_nxt = 1'b0;
          end else begin
            w_state_nxt = S_STALL;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_VECTOR;
      r_instr    <= {BITSIZE{1'b0}};
      r_instr_pc <= {BITSIZE{1'b0}};
      r_valid    <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_flush    <= w_flush_nxt;
    end
  end

  assign bus.IMemReq    = (r_state == S_FETCH);
  assign bus.IMemAddr   = r_pc;
  assign bus.InstrValid = r_valid;
  assign bus.Instr      = r_instr;
  assign bus.InstrPC    = r_instr_pc;
  assign bus.Flush      = r_flush;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter BITSIZE, default 32, giving the PC, immediate and instruction width.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- Stall  input  1  downstream cannot accept the held instruction this cycle
- BranchTaken  input  1  resolved taken branch, redirect request
- BranchPC  input  BITSIZE  PC of the resolving branch
- Immediate  input  BITSIZE  branch offset in words
- JumpEn  input  1  jump redirect request
- JumpTarget  input  BITSIZE  absolute jump byte address
- IMemReq  output  1  instruction-memory fetch request
- IMemAddr  output  BITSIZE  fetch address (current PC)
- IMemAck  input  1  instruction memory returns data this cycle
- IMemData  input  BITSIZE  fetched instruction
- InstrValid  output  1  Instr/InstrPC hold a valid instruction
- Instr  output  BITSIZE  held instruction
- InstrPC  output  BITSIZE  address of the held instruction
- Flush  output  1  one-cycle pulse on any redirect

Function
REQ-004 The block SHALL implement states IDLE, FETCH and STALL in a registered FSM.
REQ-005 IMemReq SHALL be 1 only in FETCH; IMemAddr SHALL equal the PC register in every state.
REQ-006 IDLE SHALL transition to FETCH unconditionally after one cycle, with IMemReq=0.
REQ-007 In FETCH with IMemAck=1 and no redirect, the block SHALL register Instr<=IMemData, InstrPC<=PC, InstrValid<=1 and PC<=PC+4 on the same edge, giving a one-cycle ack-to-InstrValid latency.
REQ-008 IMemAck SHALL be ignored outside FETCH.
REQ-009 In FETCH with InstrValid=1 and Stall=1, the FSM SHALL move to STALL; no ack in that cycle SHALL be accepted.
REQ-010 In STALL, IMemReq, Instr, InstrPC, InstrValid and PC SHALL hold; the FSM SHALL return to FETCH on the first cycle with Stall=0.
REQ-011 InstrValid SHALL clear on the edge after a cycle with InstrValid=1, Stall=0 and no new ack, so each instruction is presented exactly once unless stalled.
REQ-012 A redirect occurs when JumpEn=1 or BranchTaken=1, in any state except IDLE.
- JumpEn takes priority over BranchTaken.
- Jump target = {JumpTarget[BITSIZE-1:2], 2'b00}.
- Branch target = BranchPC + (Immediate<<2).
REQ-013 On a redirect edge, the block SHALL set PC<=target, InstrValid<=0, FSM<=FETCH and Flush=1 for exactly that cycle (registered Flush, asserted the following cycle for one cycle).
REQ-014 An IMemAck coinciding with a redirect SHALL be discarded, and Stall SHALL be ignored on a redirect.
REQ-015 All PC arithmetic SHALL be modulo 2^BITSIZE: PC+4 from 32'hFFFF_FFFC wraps to 0, and negative Immediate (two's complement) yields backward branches.
REQ-016 Redirect requests arriving while in IDLE SHALL be ignored.

Reset
REQ-017 When rst=1 at a clock edge, the block SHALL set PC=RESET_VECTOR, FSM=IDLE, InstrValid=0, Instr=0, InstrPC=0 and Flush=0; IMemReq SHALL be 0 the cycle after.
REQ-018 rst SHALL override every other input, including mid-fetch and mid-stall; any pending ack SHALL be dropped.

Verification
REQ-019 The bench SHALL cover reset then ack every cycle with IMemData=0x13: IMemAddr SHALL read 0x0, 0x4, 0x8; InstrPC SHALL lag by one cycle; InstrValid SHALL stay 1 continuously.
REQ-020 The bench SHALL cover Stall=1 for 3 cycles while InstrValid=1 with Instr=0xABCD: Instr SHALL be held, IMemReq SHALL be 0 for 3 cycles, and fetch SHALL resume at the unchanged PC.
REQ-021 The bench SHALL cover BranchTaken=1 with BranchPC=0x100 and Immediate=0xFFFF_FFFE: PC SHALL become 0xF8, Flush SHALL pulse once, and InstrValid SHALL be 0 the next cycle.
REQ-022 The bench SHALL cover JumpEn=1 with JumpTarget=0x203 while BranchTaken=1 and IMemAck=1 in the same cycle: PC SHALL become 0x200 and the acked data SHALL never appear on Instr.
REQ-023 The bench SHALL cover PC=0xFFFF_FFFC with an ack: the next IMemAddr SHALL be 0x0.
REQ-024 The bench SHALL cover rst asserted in STALL with InstrValid=1: the next cycle SHALL show InstrValid=0, PC=RESET_VECTOR and IMemReq=0, followed by FETCH one cycle later.
